bounce_generator: RTL and testbench

Synthesizable switch-bounce emulator: the driving end of the debounce path. On every change of a clean requested level it emits a burst of pseudo-random glitches on `o_bouncy` for a fixed window, then settles to the requested level. It feeds debounce-filter inputs in hardware self-test and on-board demos, with repeatable LFSR-driven stimulus.

---
 rtl/bounce_gen_pkg.sv | 25 ++
 rtl/bounce_generator_lfsr16.sv | 23 ++
 rtl/bounce_generator.sv | 130 +++++++++++++
 tb/tb_bounce_generator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the switch-bounce emulator.
// Latency: n/a (types, constants and pure LFSR helper functions only).
// Backpressure: n/a; nothing in this package carries flow control.
package bounce_gen_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  localparam int               LFSR_W             = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS          = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_FALLBACK_SEED = 16'hACE1;

  // One right-shifting Galois step.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // An all-zero state would lock the LFSR, so substitute the fallback seed.
  function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_FALLBACK_SEED : s;
  endfunction

endpackage

// File: rtl/bounce_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR providing repeatable pseudo-random glitch lengths.
// Latency: state advances every clock; reset loads the (zero-corrected) seed asynchronously.
// Backpressure: none; it never stalls.
import bounce_gen_pkg::*;

module lfsr16 (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;

  // Advance one step per clock; reseed on reset so stimulus is reproducible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= lfsr_seed_fix(i_seed);
    else       r_state <= lfsr_step(r_state);
  end

  assign o_state = r_state;

endmodule

// File: rtl/bounce_generator.sv
// Switch-bounce emulator: each change of i_level yields a burst of LFSR-timed glitches, then settles.
// Latency: o_bouncy follows a sampled change after 1 clock; settles BOUNCE_CYCLES clocks later.
// Backpressure: none; i_level is ignored while busy, a lingering mismatch restarts at the next IDLE edge.
// Optional edge counter output o_edges is built only when BOUNCE_GEN_COUNT_EN is defined.
import bounce_gen_pkg::*;

module bounce_generator #(
  parameter int          BOUNCE_CYCLES = 16,
  parameter int          MAX_GLITCH    = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_level,
  output logic       o_bouncy,
  output logic       o_busy,
  output logic       o_level
`ifdef BOUNCE_GEN_COUNT_EN
  ,
  output logic [7:0] o_edges
`endif
);

  localparam int               WIN_W    = $clog2(BOUNCE_CYCLES + 1);
  localparam int               SEG_W    = $clog2(MAX_GLITCH + 1);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(BOUNCE_CYCLES - 1);

  logic [LFSR_W-1:0] w_lfsr;
  logic [SEG_W-1:0]  w_seg_len;

  state_t            r_state, w_state_nxt;
  logic              r_target, w_target_nxt;
  logic              r_bouncy, w_bouncy_nxt;
  logic              r_level, w_level_nxt;
  logic [WIN_W-1:0]  r_win, w_win_nxt;
  logic [SEG_W-1:0]  r_seg, w_seg_nxt;
`ifdef BOUNCE_GEN_COUNT_EN
  logic [7:0]        r_edges, w_edges_nxt;
`endif

  lfsr16 u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_seed  (LFSR_SEED),
    .o_state (w_lfsr)
  );

  // Segment length 1..MAX_GLITCH; MAX_GLITCH is a power of two so masking the low bits suffices.
  assign w_seg_len = SEG_W'((w_lfsr & LFSR_W'(MAX_GLITCH - 1)) + LFSR_W'(1));

  // Next-state and datapath: start a burst on mismatch, toggle on segment expiry, settle at window end.
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_bouncy_nxt = r_bouncy;
    w_level_nxt  = r_level;
    w_win_nxt    = r_win;
    w_seg_nxt    = r_seg;
`ifdef BOUNCE_GEN_COUNT_EN
    w_edges_nxt  = r_edges;
`endif
    case (r_state)
      IDLE: begin
        w_bouncy_nxt = r_level;
        if (i_level != r_level) begin
          w_target_nxt = i_level;
          w_bouncy_nxt = i_level;
          w_win_nxt    = WIN_LOAD;
          w_seg_nxt    = w_seg_len;
          w_state_nxt  = BOUNCE;
`ifdef BOUNCE_GEN_COUNT_EN
          w_edges_nxt  = 8'd0;
`endif
        end
      end
      BOUNCE: begin
        if (r_win == '0) begin
          w_bouncy_nxt = r_target;
          w_level_nxt  = r_target;
          w_state_nxt  = IDLE;
        end else begin
          w_win_nxt = r_win - WIN_W'(1);
          if (r_seg == SEG_W'(1)) begin
            w_bouncy_nxt = ~r_bouncy;
            w_seg_nxt    = w_seg_len;
`ifdef BOUNCE_GEN_COUNT_EN
            if (r_edges != 8'hFF) w_edges_nxt = r_edges + 8'd1;
`endif
          end else begin
            w_seg_nxt = r_seg - SEG_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any burst immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_target <= 1'b0;
      r_bouncy <= 1'b0;
      r_level  <= 1'b0;
      r_win    <= '0;
      r_seg    <= '0;
`ifdef BOUNCE_GEN_COUNT_EN
      r_edges  <= 8'd0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_bouncy <= w_bouncy_nxt;
      r_level  <= w_level_nxt;
      r_win    <= w_win_nxt;
      r_seg    <= w_seg_nxt;
`ifdef BOUNCE_GEN_COUNT_EN
      r_edges  <= w_edges_nxt;
`endif
    end
  end

  assign o_bouncy = r_bouncy;
  assign o_level  = r_level;
  assign o_busy   = (r_state == BOUNCE);
`ifdef BOUNCE_GEN_COUNT_EN
  assign o_edges  = r_edges;
`endif

endmodule

// File: tb/tb_bounce_generator.sv
// Self-checking bench for bounce_generator against a time-scheduled reference model.
// Latency: model predicts outputs after every clock edge; checks sampled 1 time unit after the edge.
// Backpressure: n/a; stimulus is a fixed-length directed and random sequence.
module tb_bounce_generator;

  localparam int          BC   = 16;
  localparam int          MG   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_level;
  logic o_bouncy, o_busy, o_level;
`ifdef BOUNCE_GEN_COUNT_EN
  logic [7:0] o_edges;
  logic       i_level2;
  logic       o_bouncy2, o_busy2, o_level2;
  logic [7:0] o_edges2;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 i_clk = ~i_clk;

  bounce_generator #(.BOUNCE_CYCLES(BC), .MAX_GLITCH(MG), .LFSR_SEED(SEED)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_level  (i_level),
    .o_bouncy (o_bouncy),
    .o_busy   (o_busy),
    .o_level  (o_level)
`ifdef BOUNCE_GEN_COUNT_EN
    ,
    .o_edges  (o_edges)
`endif
  );

`ifdef BOUNCE_GEN_COUNT_EN
  bounce_generator #(.BOUNCE_CYCLES(600), .MAX_GLITCH(1), .LFSR_SEED(SEED)) dut_sat (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_level  (i_level2),
    .o_bouncy (o_bouncy2),
    .o_busy   (o_busy2),
    .o_level  (o_level2),
    .o_edges  (o_edges2)
  );
`endif

  // Reference model: absolute-time schedule of burst end and next toggle.
  logic [15:0] m_lfsr;
  logic        m_level, m_bouncy, m_busy, m_target;
  int          m_cyc, m_end, m_next;
`ifdef BOUNCE_GEN_COUNT_EN
  int          m_edges;
`endif

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int seg_len(input logic [15:0] s);
    return (int'(s) % MG) + 1;
  endfunction

  task automatic reset_model();
    m_lfsr = SEED; m_level = 1'b0; m_bouncy = 1'b0; m_busy = 1'b0;
    m_target = 1'b0; m_cyc = 0; m_end = 0; m_next = 0;
`ifdef BOUNCE_GEN_COUNT_EN
    m_edges = 0;
`endif
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk1("bouncy", o_bouncy, m_bouncy);
    chk1("busy", o_busy, m_busy);
    chk1("level", o_level, m_level);
`ifdef BOUNCE_GEN_COUNT_EN
    chk8("edges", o_edges, 8'(m_edges));
`endif
  endtask

  // One clock: advance the model on the edge (inputs are stable there), then check.
  task automatic tick();
    @(posedge i_clk);
    if (!i_rst) begin
      if (!m_busy) begin
        if (i_level != m_level) begin
          m_target = i_level;
          m_bouncy = i_level;
          m_busy   = 1'b1;
          m_end    = m_cyc + BC;
          m_next   = m_cyc + seg_len(m_lfsr);
`ifdef BOUNCE_GEN_COUNT_EN
          m_edges  = 0;
`endif
        end
      end else if (m_cyc == m_end) begin
        m_bouncy = m_target;
        m_level  = m_target;
        m_busy   = 1'b0;
      end else if (m_cyc == m_next) begin
        m_bouncy = ~m_bouncy;
        m_next   = m_cyc + seg_len(m_lfsr);
`ifdef BOUNCE_GEN_COUNT_EN
        if (m_edges < 255) m_edges++;
`endif
      end
      m_lfsr = lfsr_next(m_lfsr);
      m_cyc++;
    end
    #1;
    check_model();
  endtask

  logic s[0:BC-1];
  logic lv[0:99];
  logic tr[0:1][0:99];

  initial begin
    int busy_cnt, run, inv, diffs;

    // Reset held for 3 cycles with a requested level of 1: nothing may start.
    i_rst = 1'b1; i_level = 1'b1;
`ifdef BOUNCE_GEN_COUNT_EN
    i_level2 = 1'b0;
`endif
    reset_model();
    #1;
    chk1("rst_async_bouncy", o_bouncy, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk1("rst_busy", o_busy, 1'b0);
    i_level = 1'b0;
    i_rst   = 1'b0;
    tick(); tick();

    // Rising burst sampled at edge N.
    i_level = 1'b1;
    tick();
    chk1("rise_bouncy_N", o_bouncy, 1'b1);
    s[0] = o_bouncy;
    busy_cnt = o_busy ? 1 : 0;
    for (int k = 1; k < BC; k++) begin
      if (k == 5) i_level = 1'b0;  // sampled at edge N+5, must be ignored
      tick();
      s[k] = o_bouncy;
      if (o_busy) busy_cnt++;
    end
    tick();  // edge N+16
    chk8("busy_cycles", 8'(busy_cnt), 8'd16);
    chk1("settle_busy", o_busy, 1'b0);
    chk1("settle_bouncy", o_bouncy, 1'b1);
    chk1("settle_level", o_level, 1'b1);

    // Glitch bounds: every run except the truncated last one is 1..MG cycles.
    run = 1; inv = 0;
    for (int k = 1; k < BC; k++) begin
      if (s[k] != s[k-1]) begin
        chk1("run_len_in_range", (run >= 1 && run <= MG), 1'b1);
        run = 1; inv++;
      end else begin
        run++;
      end
    end
`ifdef BOUNCE_GEN_COUNT_EN
    chk8("edges_vs_counted", o_edges, 8'(inv));
`endif

    // Mismatch lingering from the ignored change starts a new burst at N+17.
    tick();
    chk1("reburst_busy", o_busy, 1'b1);
    chk1("reburst_bouncy", o_bouncy, 1'b0);
`ifdef BOUNCE_GEN_COUNT_EN
    chk8("edges_cleared", o_edges, 8'd0);
`endif
    for (int k = 0; k < BC; k++) tick();
    chk1("fall_level", o_level, 1'b0);

    // Random level changes checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) i_level = ~i_level;
      tick();
    end

    // Determinism: a fixed random stimulus replayed after two resets.
    lv[0] = 1'b1;
    for (int i = 1; i < 100; i++)
      lv[i] = ($urandom_range(0, 9) == 0) ? ~lv[i-1] : lv[i-1];

    for (int p = 0; p < 2; p++) begin
      if (p == 0) begin
        // Start a burst, then reset asynchronously 3 units after edge N+7.
        i_rst = 1'b1; reset_model(); tick();
        i_rst = 1'b0; i_level = 1'b0; tick();
        i_level = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk1("pre_rst_busy", o_busy, 1'b1);
        #2;
        i_rst = 1'b1;
        reset_model();
        #1;
        chk1("midrst_bouncy", o_bouncy, 1'b0);
        chk1("midrst_busy", o_busy, 1'b0);
        chk1("midrst_level", o_level, 1'b0);
      end else begin
        i_rst = 1'b1;
        reset_model();
      end
      tick(); tick();
      i_rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
        i_level = lv[i];
        tick();
        tr[p][i] = o_bouncy;
      end
    end
    diffs = 0;
    for (int i = 0; i < 100; i++) if (tr[0][i] !== tr[1][i]) diffs++;
    chk8("replay_diffs", 8'(diffs), 8'd0);

`ifdef BOUNCE_GEN_COUNT_EN
    // Saturation: 600-cycle window with 1-cycle glitches gives 599 toggles.
    i_level2 = 1'b1;
    tick();
    chk1("sat_busy_start", o_busy2, 1'b1);
    for (int k = 0; k < 600; k++) tick();
    chk1("sat_busy_end", o_busy2, 1'b0);
    chk1("sat_level", o_level2, 1'b1);
    chk8("sat_edges", o_edges2, 8'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
